// File: rtl/qtable_writeback_if.sv
// qtable_writeback_if: update, RAM write-port and forwarding-lookup signals of the write-back stage
interface qtable_writeback_if #(
    parameter int STATE_W = 6,
    parameter int ACT_W   = 4,
    parameter int Q_W     = 16,
    parameter int DEPTH   = 4
);
    localparam int KW = STATE_W + ACT_W;
    localparam int PW = $clog2(DEPTH) + 1;

    logic               upd_valid;
    logic [STATE_W-1:0] upd_state;
    logic [ACT_W-1:0]   upd_action;
    logic [Q_W-1:0]     upd_q;
    logic               upd_ready;
    logic               ram_grant;
    logic               ram_we;
    logic [KW-1:0]      ram_addr;
    logic [Q_W-1:0]     ram_wdata;
    logic [STATE_W-1:0] rd_state;
    logic [ACT_W-1:0]   rd_action;
    logic               fwd_hit;
    logic [Q_W-1:0]     fwd_q;
    logic [PW-1:0]      pending;
    logic               overflow;

    modport master (
        output upd_valid, upd_state, upd_action, upd_q, ram_grant, rd_state, rd_action,
        input  upd_ready, ram_we, ram_addr, ram_wdata, fwd_hit, fwd_q, pending, overflow
    );

    modport slave (
        input  upd_valid, upd_state, upd_action, upd_q, ram_grant, rd_state, rd_action,
        output upd_ready, ram_we, ram_addr, ram_wdata, fwd_hit, fwd_q, pending, overflow
    );
endinterface

// File: rtl/qtable_writeback.sv
// qtable_writeback: coalescing pending-update buffer feeding the Q-table RAM write port, with read-after-write forwarding
module qtable_writeback #(
    parameter int STATE_W = 6,
    parameter int ACT_W   = 4,
    parameter int Q_W     = 16,
    parameter int DEPTH   = 4
) (
    input logic            clk,
    input logic            rst,
    qtable_writeback_if.slave bus
);
    localparam int KW    = STATE_W + ACT_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int PW    = PTR_W + 1;

    logic [KW-1:0]    key_q [DEPTH];
    logic [KW-1:0]    key_d [DEPTH];
    logic [Q_W-1:0]   val_q [DEPTH];
    logic [Q_W-1:0]   val_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d, we_q, we_d;
    logic [KW-1:0]    addr_q, addr_d;
    logic [Q_W-1:0]   wdata_q, wdata_d;
    logic [DEPTH-1:0] live, match;
    logic [PTR_W-1:0] off, slot;
    logic [KW-1:0]    upd_key, rd_key;
    logic             pop, full, append, drop, fwd_hit;
    logic [Q_W-1:0]   fwd_q;

    assign upd_key = {bus.upd_state, bus.upd_action};
    assign rd_key  = {bus.rd_state, bus.rd_action};
    assign full    = cnt_q == PW'(DEPTH);
    assign pop     = bus.ram_grant && cnt_q != '0;
    assign append  = bus.upd_valid && match == '0 && !full;
    assign drop    = bus.upd_valid && match == '0 && full;

    // Occupied slots, and the slot an incoming update coalesces into (never the head being popped)
    always_comb begin
        live  = '0;
        match = '0;
        off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off      = PTR_W'(i) - head_q;
            live[i]  = {1'b0, off} < cnt_q;
            match[i] = bus.upd_valid && live[i] && key_q[i] == upd_key && !(pop && PTR_W'(i) == head_q);
        end
    end

    // Next buffer contents, pointers, occupancy, sticky overflow and RAM-port stage
    always_comb begin
        key_d   = key_q;
        val_d   = val_q;
        head_d  = pop ? head_q + 1'b1 : head_q;
        tail_d  = append ? tail_q + 1'b1 : tail_q;
        cnt_d   = cnt_q + PW'(append) - PW'(pop);
        ovf_d   = ovf_q | drop;
        we_d    = pop;
        addr_d  = pop ? key_q[head_q] : addr_q;
        wdata_d = pop ? val_q[head_q] : wdata_q;
        for (int i = 0; i < DEPTH; i++)
            if (match[i]) val_d[i] = bus.upd_q;
        if (append) begin
            key_d[tail_q] = upd_key;
            val_d[tail_q] = bus.upd_q;
        end
    end

    // State registers; reset empties the buffer and kills any write in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i] <= '0;
                val_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            key_q   <= key_d;
            val_q   <= val_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Forwarding: in-flight write lowest priority, then slots oldest to newest so the newest match wins
    always_comb begin
        slot    = head_q;
        fwd_hit = we_q && addr_q == rd_key;
        fwd_q   = fwd_hit ? wdata_q : '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_q + PTR_W'(k);
            if (PW'(k) < cnt_q && key_q[slot] == rd_key) begin
                fwd_hit = 1'b1;
                fwd_q   = val_q[slot];
            end
        end
    end

    assign bus.upd_ready = !full;
    assign bus.ram_we    = we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.fwd_hit   = fwd_hit;
    assign bus.fwd_q     = fwd_q;
    assign bus.pending   = cnt_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_qtable_writeback.sv
// tb_qtable_writeback: directed and randomized checks of qtable_writeback against a queue-based model
module tb_qtable_writeback;
    localparam int SW = 6;
    localparam int AW = 4;
    localparam int QW = 16;
    localparam int DEPTH = 4;

    typedef struct {
        logic [SW+AW-1:0] k;
        logic [QW-1:0]    v;
    } ent_t;

    logic clk, rst;
    int   nchk = 0;
    int   nerr = 0;

    qtable_writeback_if #(.STATE_W(SW), .ACT_W(AW), .Q_W(QW), .DEPTH(DEPTH)) bus ();
    qtable_writeback #(.STATE_W(SW), .ACT_W(AW), .Q_W(QW), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ent_t             mq[$];
    ent_t             e;
    bit               m_we, m_ovf, mpop;
    logic [SW+AW-1:0] m_addr, uk;
    logic [QW-1:0]    m_wd;
    int               n, hit;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: an ordered list of pending {key,q}; oldest at index 0
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_we = 0; m_ovf = 0; m_addr = '0; m_wd = '0;
        end else begin
            n = mq.size();
            mpop = bus.ram_grant && n > 0;
            uk = {bus.upd_state, bus.upd_action};
            hit = -1;
            if (bus.upd_valid)
                for (int i = (mpop ? 1 : 0); i < n; i++)
                    if (mq[i].k == uk) hit = i;
            if (bus.upd_valid && hit >= 0) mq[hit].v = bus.upd_q;
            if (mpop) begin
                m_we = 1; m_addr = mq[0].k; m_wd = mq[0].v;
                void'(mq.pop_front());
            end else m_we = 0;
            if (bus.upd_valid && hit < 0) begin
                if (n < DEPTH) begin
                    e.k = uk; e.v = bus.upd_q;
                    mq.push_back(e);
                end else m_ovf = 1;
            end
        end
    end

    function automatic void mfwd(output bit h, output logic [QW-1:0] v);
        h = 0; v = '0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (!h && mq[i].k == {bus.rd_state, bus.rd_action}) begin h = 1; v = mq[i].v; end
        if (!h && m_we && m_addr == {bus.rd_state, bus.rd_action}) begin h = 1; v = m_wd; end
    endfunction

    // Every-cycle comparison of all outputs against the model, midway between edges
    always @(negedge clk) begin
        bit            fh;
        logic [QW-1:0] fq;
        mfwd(fh, fq);
        chk("m_ram_we", bus.ram_we, m_we);
        chk("m_ram_addr", bus.ram_addr, m_addr);
        chk("m_ram_wdata", bus.ram_wdata, m_wd);
        chk("m_pending", bus.pending, mq.size());
        chk("m_upd_ready", bus.upd_ready, mq.size() < DEPTH);
        chk("m_overflow", bus.overflow, m_ovf);
        chk("m_fwd_hit", bus.fwd_hit, fh);
        chk("m_fwd_q", bus.fwd_q, fq);
    end

    task automatic cyc(input bit v, input int s, input int a, input int q, input bit g, input int rs, input int ra);
        bus.upd_valid = v;
        bus.upd_state = SW'(s);
        bus.upd_action = AW'(a);
        bus.upd_q = QW'(q);
        bus.ram_grant = g;
        bus.rd_state = SW'(rs);
        bus.rd_action = AW'(ra);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int gp;
        rst = 1'b1;
        bus.upd_valid = 0; bus.upd_state = '0; bus.upd_action = '0; bus.upd_q = '0;
        bus.ram_grant = 0; bus.rd_state = '0; bus.rd_action = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", bus.ram_we, 0);
        chk("rst_pending", bus.pending, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_ready", bus.upd_ready, 1);
        chk("rst_fwd_hit", bus.fwd_hit, 0);
        chk("rst_fwd_q", bus.fwd_q, 0);
        rst = 1'b0;

        cyc(1, 5, 2, 'h1234, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("wt_we", bus.ram_we, 1);
        chk("wt_addr", bus.ram_addr, 'h52);
        chk("wt_wdata", bus.ram_wdata, 'h1234);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("wt_we_off", bus.ram_we, 0);
        chk("wt_addr_hold", bus.ram_addr, 'h52);

        cyc(1, 3, 1, 'h0010, 0, 3, 1);
        chk("co_fwd_first", bus.fwd_q, 'h0010);
        cyc(1, 3, 1, 'h0020, 0, 3, 1);
        chk("co_pending", bus.pending, 1);
        chk("co_fwd_hit", bus.fwd_hit, 1);
        chk("co_fwd_q", bus.fwd_q, 'h0020);
        cyc(0, 0, 0, 0, 1, 3, 1);
        chk("co_we", bus.ram_we, 1);
        chk("co_addr", bus.ram_addr, 'h31);
        chk("co_wdata", bus.ram_wdata, 'h0020);
        cyc(0, 0, 0, 0, 1, 3, 1);
        chk("co_single_write", bus.ram_we, 0);
        chk("co_fwd_gone", bus.fwd_hit, 0);

        for (int i = 0; i < 4; i++) cyc(1, 1, i, 'hA0 + i, 0, 0, 0);
        chk("full_pending", bus.pending, 4);
        chk("full_ready", bus.upd_ready, 0);
        chk("full_no_ovf", bus.overflow, 0);
        cyc(1, 2, 0, 'h00FF, 0, 2, 0);
        chk("ovf_set", bus.overflow, 1);
        chk("ovf_pending", bus.pending, 4);
        chk("ovf_not_fwd", bus.fwd_hit, 0);
        cyc(1, 1, 1, 'h0055, 0, 1, 1);
        chk("full_coal_pending", bus.pending, 4);
        chk("full_coal_fwd", bus.fwd_q, 'h0055);

        cyc(1, 2, 1, 'h0077, 1, 2, 1);
        chk("popfull_pending", bus.pending, 3);
        chk("popfull_ovf", bus.overflow, 1);
        chk("popfull_addr", bus.ram_addr, 'h10);
        chk("popfull_wdata", bus.ram_wdata, 'hA0);
        chk("popfull_not_fwd", bus.fwd_hit, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 1, 0, 0);
            if (i == 0) chk("drain_coal_wdata", bus.ram_wdata, 'h0055);
            chk("drop_never_written", bus.ram_we && (bus.ram_addr == 'h20 || bus.ram_addr == 'h21), 0);
        end
        chk("drain_pending", bus.pending, 0);

        cyc(1, 7, 0, 'hBEEF, 1, 7, 0);
        chk("if_buf_hit", bus.fwd_hit, 1);
        cyc(0, 0, 0, 0, 1, 7, 0);
        chk("if_we", bus.ram_we, 1);
        chk("if_empty", bus.pending, 0);
        chk("if_hit", bus.fwd_hit, 1);
        chk("if_q", bus.fwd_q, 'hBEEF);
        cyc(0, 0, 0, 0, 1, 7, 0);
        chk("if_hit_gone", bus.fwd_hit, 0);
        chk("if_q_gone", bus.fwd_q, 0);

        for (int i = 1; i < 4; i++) cyc(1, 0, i, 'h100 + i, 0, 0, 1);
        cyc(1, 0, 4, 'h104, 1, 0, 1);
        chk("pre_rst_pending", bus.pending, 3);
        chk("pre_rst_we", bus.ram_we, 1);
        chk("pre_rst_fwd", bus.fwd_q, 'h101);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_we", bus.ram_we, 0);
        chk("mid_rst_pending", bus.pending, 0);
        chk("mid_rst_overflow", bus.overflow, 0);
        chk("mid_rst_ready", bus.upd_ready, 1);
        chk("mid_rst_fwd", bus.fwd_hit, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        gp = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) gp = $urandom_range(0, 100);
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 65535),
                $urandom_range(0, 99) < gp, $urandom_range(0, 3), $urandom_range(0, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/qtable_writeback.md
# qtable_writeback

Write-back stage of the Q-learning datapath. It accepts updated Q-values with their state/action coordinates, after the action, state and Q-value delay stages have aligned them. It buffers them in a small coalescing FIFO and issues them to the Q-table RAM write port whenever the port is granted. It also provides read-after-write forwarding, so the read side never consumes a Q-value whose update is still pending.

## Interface
Parameters:
- STATE_W, 6, state index width
- ACT_W, 4, action index width
- Q_W, 16, Q-value width
- DEPTH, 4, pending-update buffer entries (power of two, ≥2)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- upd_valid  in  1  update present this cycle
- upd_state  in  STATE_W  state of update
- upd_action  in  ACT_W  action of update
- upd_q  in  Q_W  new Q-value
- upd_ready  out  1  buffer can accept a non-coalescing update
- ram_grant  in  1  RAM write port available this cycle
- ram_we  out  1  registered write enable
- ram_addr  out  STATE_W+ACT_W  registered address {state, action}
- ram_wdata  out  Q_W  registered write data
- rd_state  in  STATE_W  read-side lookup state
- rd_action  in  ACT_W  read-side lookup action
- fwd_hit  out  1  lookup address has a pending write (combinational)
- fwd_q  out  Q_W  newest pending value for lookup (combinational)
- pending  out  clog2(DEPTH)+1  buffer occupancy
- overflow  out  1  sticky: an update was dropped

## Operation
- Reset sets the buffer empty. All outputs go to 0: ram_we, ram_addr, ram_wdata, pending, overflow, fwd_hit and fwd_q. upd_ready goes to 1.
- Key is {upd_state, upd_action}. Buffer entries hold {key, q}.
- Pop: if ram_grant=1 and pending>0, the head entry is removed. Next cycle ram_we=1, ram_addr=head key and ram_wdata=head q. Otherwise ram_we=0 next cycle, and ram_addr/ram_wdata hold their values.
- Coalesce: if upd_valid and the key matches a valid entry that is not being popped this cycle, that entry's q is overwritten in place. pending is unchanged, and coalescing is allowed even when the buffer is full. At most one entry per key ever exists.
- Append: if upd_valid and there is no coalescing match, the update is appended at the tail when pending<DEPTH. This includes a match on the head being popped this cycle, which is appended as a new entry.
- Drop: if an append is needed and pending==DEPTH, the update is dropped and overflow is set. overflow stays 1 until reset.
- A full buffer drops the update even when a pop occurs in the same cycle: acceptance depends only on the pre-edge count.
- upd_ready = (pending<DEPTH). Upstream has no stall, so upd_ready is advisory only.
- Simultaneous pop and append: pending is unchanged and both pointers advance.
- Forwarding lookup order, newest first:
  1. buffer entries, tail to head;
  2. the ram_we output stage (a write in flight during the current cycle).
- First match drives fwd_hit=1 and fwd_q. With no match, fwd_hit=0 and fwd_q=0. The upd_* inputs of the current cycle are not forwarded.

## Timing
- Latency from accepted update to ram_we is 2 cycles minimum: 1 cycle to enter the buffer, then a pop with grant, then the registered output. Equivalently, the update is on the RAM port in the cycle after the pop edge.
- Throughput is one update accepted and one RAM write per cycle.
- pending, pointers and overflow update on the clock edge. fwd_* reflect the post-edge state within the same cycle.
- Reset asserted mid-operation clears everything on assertion, independent of clk. Buffered updates are discarded and ram_we drops to 0 immediately.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by pending, not by pointer equality.

## Test plan
- Reset/idle: assert rst mid-stream with 3 entries pending -> ram_we=0, pending=0, overflow=0 and upd_ready=1 immediately.
- Single write-through: ram_grant=1; update (state=5, action=2, q=0x1234) -> two cycles later ram_we=1, ram_addr=0x52, ram_wdata=0x1234.
- Coalesce and forward: ram_grant=0; updates (3,1,0x0010) then (3,1,0x0020) -> pending=1. Lookup (3,1) gives fwd_hit=1, fwd_q=0x0020. Grant -> exactly one RAM write of 0x0020.
- Full and overflow: ram_grant=0; 4 distinct keys, then a 5th distinct key -> pending=4, upd_ready=0, overflow=1, 5th key never written. A 6th update to an existing key still coalesces.
- Simultaneous pop and append at full: pending=4, ram_grant=1, new distinct key -> pop occurs, new key dropped, overflow=1, pending=3.
- In-flight forwarding: write (7,0,0xBEEF) on the RAM port with the buffer empty, lookup (7,0) -> fwd_hit=1, fwd_q=0xBEEF. The next cycle, with no further write to that key -> fwd_hit=0.
